// File: rtl/imem_boot_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to sequential imem addresses.
// Holds the CPU in reset until the requested number of words is loaded; 4 bytes per 5 cycles at full rate.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    typedef enum logic [1:0] {HOLD, RECV, WRITE, RUN} state_t;

    state_t          state;
    logic [ADDR_W:0] len;
    logic [1:0]      byte_cnt;
    logic [23:0]     word;
    logic [ADDR_W:0] start_len;
    logic [ADDR_W:0] wl_next;

    // Saturating the length keeps the address counter from ever wrapping.
    assign start_len = (load_len > DEPTH_V) ? DEPTH_V : load_len;
    assign wl_next   = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= HOLD;
            len          <= '0;
            byte_cnt     <= 2'd0;
            word         <= 24'd0;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
        end else begin
            done    <= 1'b0;
            imem_we <= 1'b0;
            case (state)
                HOLD, RUN: begin
                    if (load_start) begin
                        len          <= start_len;
                        words_loaded <= '0;
                        byte_cnt     <= 2'd0;
                        imem_addr    <= '0;
                        if (start_len == '0) begin
                            state     <= RUN;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b0;
                        end else begin
                            state     <= RECV;
                            cpu_reset <= 1'b1;
                            busy      <= 1'b1;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (in_valid && in_ready) begin
                        word     <= {word[15:0], in_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state      <= WRITE;
                            in_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= words_loaded[ADDR_W-1:0];
                            imem_wdata <= {word, in_byte};
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= wl_next;
                    if (wl_next == len) begin
                        state     <= RUN;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule
